fft_reorder: RTL and testbench

Parametrised output-reordering stage for the pipelined FFT. It sits after the last butterfly stage, where samples arrive in bit-reversed index order. Generalises the fixed 16-point, 19-bit bit-reversal stage to any power-of-two size and any sample width. Adds a run-time natural or bit-reversed order select, a frame-resync error flag, and frame-gated start.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_reorder_mem.sv | 40 ++++
 rtl/fft_reorder.sv | 133 +++++++++++++
 tb/tb_fft_reorder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the pipelined FFT datapath.
//   Latency: n/a (package only).
//   Backpressure: n/a; provides bitrev() and the legal LGSIZE range check.
//
// Contents:
//   LGSIZE_MIN / LGSIZE_MAX : legal range of log2(FFT length)
//   bitrev(val, lg)         : reverse the low lg bits of val, upper bits zero
//   lgsize_legal(lg)        : elaboration-time range check helper
package fft_pkg;

  localparam int LGSIZE_MIN = 2;
  localparam int LGSIZE_MAX = 12;

  // Reverse the whole LGSIZE_MAX-bit word, then shift the reversed low
  // field back down so only the low i_lg bits carry the result.
  function automatic logic [LGSIZE_MAX-1:0] bitrev(input logic [LGSIZE_MAX-1:0] i_val,
                                                   input int i_lg);
    logic [LGSIZE_MAX-1:0] w_rev;
    w_rev = {<<{i_val}};
    return w_rev >> (LGSIZE_MAX - i_lg);
  endfunction

  function automatic bit lgsize_legal(input int i_lg);
    return (i_lg >= LGSIZE_MIN) && (i_lg <= LGSIZE_MAX);
  endfunction

endpackage

// File: rtl/fft_reorder_mem.sv
// fft_reorder_mem: simple dual-port RAM holding both ping-pong banks.
//   Latency: 1 enabled cycle from read address to o_rdata.
//   Backpressure: none; both ports advance only on i_ce.
//
// Ports:
//   i_clk            clock
//   i_ce             clock enable for both ports
//   i_we             write strobe (qualified by i_ce)
//   i_waddr/i_wdata  write port; address MSB is the bank select
//   i_raddr          read address; address MSB is the bank select
//   o_rdata          registered read data
module fft_reorder_mem
  import fft_pkg::*;
#(
  parameter int AW    = 5,
  parameter int WIDTH = 38
) (
  input  logic             i_clk,
  input  logic             i_ce,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

  // No reset on the array or the read register: contents are only
  // consumed once the control logic marks a bank as holding a full frame.
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong bit-reversal reorder stage after the last butterfly.
//   Latency: sample 0 accepted in enabled cycle k appears after the edge of k+N+1.
//   Backpressure: none; i_ce stalls everything, one sample in/out per enabled cycle.
//
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_ce            clock enable
//   i_sync          marks input sample 0 of a frame (qualified by i_ce)
//   i_order         0 = natural output order, 1 = arrival (bit-reversed) order
//   i_sample        input sample, opaque WIDTH bits
//   o_result        registered reordered sample
//   o_sync          high with output sample 0 of each valid frame
//   o_err           one-enabled-cycle pulse after a mid-frame i_sync
module fft_reorder
  import fft_pkg::*;
#(
  parameter int LGSIZE = 4,
  parameter int WIDTH  = 38
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic             i_sync,
  input  logic             i_order,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_result,
  output logic             o_sync,
  output logic             o_err
);

  if (!lgsize_legal(LGSIZE)) begin : g_lgsize_check
    $fatal(1, "fft_reorder: LGSIZE outside legal range");
  end

  localparam int              AW       = LGSIZE + 1;
  localparam logic [LGSIZE-1:0] LAST_IDX = {LGSIZE{1'b1}};

  // Control state
  logic              r_started;   // first i_sync seen since reset
  logic              r_bank;      // bank currently being written
  logic              r_rd_valid;  // opposite bank holds a complete frame
  logic              r_order_q;   // order used for the frame being read
  logic [LGSIZE-1:0] r_wcnt;
  logic [LGSIZE-1:0] r_rcnt;

  // Read pipeline tags, aligned with the RAM read register
  logic              r_rd_first;
  logic              r_rd_vld;

  logic [LGSIZE-1:0] w_wbase;
  logic              w_we;
  logic              w_swap;
  logic              w_mid;
  logic [LGSIZE-1:0] w_rev;
  logic [LGSIZE-1:0] w_raddr_lo;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [WIDTH-1:0]  w_rdata;

  // An i_sync always forces the sample to address 0. At a normal frame
  // boundary wcnt is already 0, so the same path covers both the start,
  // the regular boundary and a mid-frame resync.
  assign w_wbase = i_sync ? '0 : r_wcnt;
  assign w_we    = i_ce & (r_started | i_sync);
  assign w_swap  = w_we & (w_wbase == LAST_IDX);
  assign w_mid   = i_ce & i_sync & (r_wcnt != '0);

  // Bank contents are in arrival order: address p holds natural index
  // bitrev(p). Natural-order output therefore reads bitrev(rcnt).
  assign w_rev      = LGSIZE'(bitrev(LGSIZE_MAX'(r_rcnt), LGSIZE));
  assign w_raddr_lo = r_order_q ? r_rcnt : w_rev;

  assign w_waddr = {r_bank, w_wbase};
  assign w_raddr = {~r_bank, w_raddr_lo};

  fft_reorder_mem #(
    .AW    (AW),
    .WIDTH (WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_ce    (i_ce),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_sample),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_started  <= 1'b0;
      r_bank     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_order_q  <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_rd_first <= 1'b0;
      r_rd_vld   <= 1'b0;
      o_result   <= '0;
      o_sync     <= 1'b0;
      o_err      <= 1'b0;
    end else if (i_ce) begin
      if (w_we) begin
        r_started <= 1'b1;
        r_wcnt    <= w_wbase + LGSIZE'(1);
      end

      if (w_swap) begin
        r_bank     <= ~r_bank;
        r_rcnt     <= '0;
        r_rd_valid <= 1'b1;
        r_order_q  <= i_order;
      end else begin
        r_rcnt <= r_rcnt + LGSIZE'(1);
        // The frame in the read bank stays readable, but the stream is
        // no longer continuous: hold o_sync off until the new frame lands.
        if (w_mid) begin
          r_rd_valid <= 1'b0;
        end
      end

      // Tags travel with the read issued this cycle
      r_rd_first <= r_rd_valid & (r_rcnt == '0);
      r_rd_vld   <= r_rd_valid;

      // Zero outside valid frames keeps unwritten RAM off the output
      o_result <= r_rd_vld ? w_rdata : '0;
      o_sync   <= r_rd_first;
      o_err    <= w_mid;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
module tb_fft_reorder;

  localparam int LG   = 4;
  localparam int N    = 16;
  localparam int W    = 38;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         sync;
  logic         ord;
  logic [W-1:0] smp;
  logic [W-1:0] res;
  logic         osync;
  logic         oerr;

  always #5 clk = ~clk;

  fft_reorder #(
    .LGSIZE (LG),
    .WIDTH  (W)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_ce     (ce),
    .i_sync   (sync),
    .i_order  (ord),
    .i_sample (smp),
    .o_result (res),
    .o_sync   (osync),
    .o_err    (oerr)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: frames collected by arrival position, then an
  // output schedule indexed by enabled-edge number.
  int           e_idx = 0;
  bit           m_started = 0;
  int           m_pos = 0;
  logic [W-1:0] fbuf [N];
  bit           sch_vld [MAXE];
  bit           sch_syn [MAXE];
  logic [W-1:0] sch_dat [MAXE];
  bit           m_vld = 0, m_syn = 0, m_err = 0, m_any = 0;
  logic [W-1:0] m_dat = '0;
  bit           chk_en = 0;
  bit           watch = 0;
  int           first_sync_e = -1;
  int           sync_e = 0;

  int lit_rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int brev(input int p);
    int r = 0;
    for (int b = 0; b < LG; b++) if (((p >> b) & 1) != 0) r |= (1 << (LG - 1 - b));
    return r;
  endfunction

  // Sample arriving at position p carries natural index bitrev(p), tagged by frame id
  function automatic logic [W-1:0] val(input int id, input int p);
    return (W'(id) << 8) | W'(brev(p));
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t edge %0d: got %h, expected %h", name, $time, e_idx, act, exp);
    end
  endtask

  task automatic clear_from(input int from);
    for (int i = from; i < from + 2 * N + 4 && i < MAXE; i++) begin
      sch_vld[i] = 0;
      sch_syn[i] = 0;
    end
  endtask

  task automatic model_edge(input bit c, input bit s, input bit o, input bit r,
                            input logic [W-1:0] d);
    logic [W-1:0] outv;
    bit mid;
    if (r) begin
      e_idx++;
      clear_from(e_idx);
      m_started = 0;
      m_pos = 0;
      m_err = 0;
      m_any = 0;
    end else if (c) begin
      e_idx++;
      mid = 0;
      if (s) begin
        if (m_started && m_pos != 0) begin
          mid = 1;
          clear_from(e_idx + 2);
        end
        m_started = 1;
        m_pos = 0;
      end
      if (m_started) begin
        fbuf[m_pos] = d;
        m_pos++;
        if (m_pos == N) begin
          for (int j = 0; j < N; j++) begin
            outv = o ? fbuf[j] : fbuf[brev(j)];
            if (e_idx + 2 + j < MAXE) begin
              sch_vld[e_idx + 2 + j] = 1;
              sch_syn[e_idx + 2 + j] = (j == 0);
              sch_dat[e_idx + 2 + j] = outv;
            end
            if ((outv >> 8) == W'(1)) check("model_nat_pin", W'(outv[7:0]), W'(j));
            if ((outv >> 8) == W'(4)) check("model_rev_pin", W'(outv[7:0]), W'(lit_rev[j]));
          end
          m_any = 1;
          m_pos = 0;
        end
      end
      m_err = mid;
    end
    if (e_idx < MAXE) begin
      m_vld = sch_vld[e_idx];
      m_syn = sch_syn[e_idx];
      m_dat = sch_dat[e_idx];
    end
  endtask

  task automatic cyc(input bit c, input bit s, input bit o, input bit r, input logic [W-1:0] d);
    ce = c;
    sync = s;
    ord = o;
    rst = r;
    smp = d;
    @(posedge clk);
    #1;
    model_edge(c, s, o, r, d);
  endtask

  // One frame of nsamp samples, sync on the first; order switches from o0
  // to o1 at sample flip_at; rnd inserts random disabled cycles.
  task automatic frame(input int id, input int nsamp, input bit o0, input bit o1,
                       input int flip_at, input bit rnd);
    bit on;
    for (int p = 0; p < nsamp; p++) begin
      on = (p < flip_at) ? o0 : o1;
      if (rnd) begin
        for (int g = 0; g < 6 && $urandom_range(1, 0) == 0; g++)
          cyc(0, 1'($urandom_range(1, 0)), on, 0, W'($urandom));
      end
      cyc(1, p == 0, on, 0, val(id, p));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_sync", W'(osync), W'(m_syn));
      check("o_err", W'(oerr), W'(m_err));
      if (m_vld) check("o_result", res, m_dat);
      else if (!m_any) check("o_result_idle", res, '0);
      if (watch && osync && first_sync_e < 0) first_sync_e = e_idx;
    end
  end

  initial begin
    cyc(1, 0, 0, 1, '0);
    chk_en = 1;
    repeat (2) cyc(1, 0, 0, 1, '0);

    // No sync: nothing starts
    repeat (40) cyc(1, 0, 0, 0, W'($urandom));

    // Natural order, continuous; first o_sync 17 edges after the sync edge
    watch = 1;
    first_sync_e = -1;
    sync_e = e_idx + 1;
    frame(1, N, 0, 0, N, 0);
    frame(2, N, 0, 0, N, 0);
    frame(3, N, 0, 0, N, 0);
    check("sync_latency", W'(first_sync_e - sync_e), W'(17));
    watch = 0;

    // Arrival order
    frame(4, N, 1, 1, N, 0);
    frame(5, N, 1, 1, N, 0);

    // Random clock enable
    frame(6, N, 0, 0, N, 1);
    frame(7, N, 0, 0, N, 1);
    frame(8, N, 0, 0, N, 1);

    // Resync at input sample 7
    frame(10, 7, 0, 0, N, 0);
    frame(11, N, 0, 0, N, 0);
    frame(12, N, 0, 0, N, 0);
    frame(13, N, 0, 0, N, 0);

    // Order flipped at sample 5
    frame(20, N, 0, 1, 5, 0);
    frame(21, N, 1, 1, N, 0);
    frame(22, N, 1, 1, N, 0);

    // Reset while output frame is mid-stream, then wait for a new sync
    frame(30, N, 0, 0, N, 0);
    frame(31, N, 0, 0, N, 0);
    frame(32, 10, 0, 0, N, 0);
    cyc(1, 0, 0, 1, '0);
    repeat (40) cyc(1, 0, 0, 0, W'($urandom));
    frame(33, N, 0, 0, N, 0);
    frame(34, N, 1, 1, N, 1);
    frame(35, N, 0, 0, N, 0);
    repeat (N + 4) cyc(1, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
